// File: rtl/cpu_pkg.sv
// cpu_pkg: flag indices, branch encodings and ALU op codes shared across the execute stage
package cpu_pkg;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_JZ   = 3'd1;
    localparam logic [2:0] BR_JN   = 3'd2;
    localparam logic [2:0] BR_JC   = 3'd3;
    localparam logic [2:0] BR_JV   = 3'd4;
    localparam logic [2:0] BR_JMP  = 3'd5;
    typedef logic [3:0] flags_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_OR,
        ALU_XOR, ALU_RLC, ALU_RRC, ALU_PASS
    } alu_op_e;
endpackage

// File: rtl/ccr_shadow_stack.sv
// ccr_shadow_stack: saturating LIFO of flag snapshots with sticky misuse detection
module ccr_shadow_stack
    import cpu_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    parameter int PTR_W = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   push,
    input  logic   pop,
    input  flags_t push_data,
    output flags_t pop_data,
    output logic   pop_valid,
    output logic   empty,
    output logic   full,
    output logic   err
);
    logic [PTR_W-1:0] ptr_q, ptr_d;
    flags_t mem_q [0:(1<<PTR_W)-1];
    logic err_q, err_d, do_push;

    assign empty     = ptr_q == '0;
    assign full      = ptr_q == PTR_W'(SHADOW_DEPTH);
    assign do_push   = en & push & ~pop & ~full;
    assign pop_valid = en & pop & ~push & ~empty;
    assign pop_data  = mem_q[ptr_q - PTR_W'(1)];
    assign ptr_d     = do_push ? ptr_q + PTR_W'(1) : pop_valid ? ptr_q - PTR_W'(1) : ptr_q;
    assign err_d     = err_q | (en & ((push & pop) | (push & full) | (pop & empty)));
    assign err       = err_q;

    // pointer, snapshot storage and sticky error; overflowing pushes are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < (1 << PTR_W); i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
            if (do_push) mem_q[ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register with branch evaluation and interrupt flag shadowing
// Build option CCR_FWD_EN: branch and carry_in see this cycle's ALU flags instead of the registered ones.
module ccr_unit
    import cpu_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_cout,
    input  logic       alu_overflow,
    input  logic       ex_valid,
    input  logic       stall,
    input  logic [3:0] upd_mask,
    input  logic [2:0] br_cond,
    input  logic       int_save,
    input  logic       rti_restore,
    output logic [3:0] ccr,
    output logic       carry_in,
    output logic       br_taken,
    output logic       shadow_empty,
    output logic       shadow_full,
    output logic       ccr_err
);
    flags_t ccr_q, ccr_d, alu_f, wr, upd, f, clr, ccr_next, pop_data;
    logic en, hit, pop_valid;

    assign en    = ~stall;
    assign alu_f = {alu_overflow, alu_cout, alu_neg, alu_zero};
    assign wr    = ex_valid ? upd_mask : '0;
    assign upd   = (wr & alu_f) | (~wr & ccr_q);
`ifdef CCR_FWD_EN
    assign f = upd;
`else
    assign f = ccr_q;
`endif
    assign hit = (br_cond == BR_JMP) | ((br_cond == BR_JZ) & f[FLAG_Z]) |
                 ((br_cond == BR_JN) & f[FLAG_N]) | ((br_cond == BR_JC) & f[FLAG_C]) |
                 ((br_cond == BR_JV) & f[FLAG_V]);
    assign br_taken = ex_valid & hit;
    assign clr = {4{br_taken}} & {br_cond == BR_JV, br_cond == BR_JC, br_cond == BR_JN, br_cond == BR_JZ};
    // a same-cycle ALU write to the tested flag beats the branch consume
    assign ccr_next = upd & ~(clr & ~wr);
    assign ccr_d    = pop_valid ? pop_data : ccr_next;
    assign ccr      = ccr_q;
    assign carry_in = f[FLAG_C];

    ccr_shadow_stack #(.SHADOW_DEPTH(SHADOW_DEPTH), .PTR_W(PTR_W)) u_stack (
        .clk(clk), .reset(reset), .en(en), .push(int_save), .pop(rti_restore),
        .push_data(ccr_next), .pop_data(pop_data), .pop_valid(pop_valid),
        .empty(shadow_empty), .full(shadow_full), .err(ccr_err)
    );

    // flag register; stall freezes it, a valid RTI overrides the normal update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ccr_q <= '0;
        else if (en) ccr_q <= ccr_d;
    end
endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition-code register stage directly downstream of the 8-bit ALU in the execute stage.
- Latches the ALU flag outputs (zero, neg, cout, overflow) under a per-instruction update mask.
- Feeds the registered carry back to the ALU for rotate-through-carry, and evaluates branch conditions for the fetch/decode stage.
- Holds a small shadow stack so flags are saved on interrupt entry and restored on RTI.

Parameters:
- SHADOW_DEPTH, 2, number of nested interrupt flag snapshots held (1..4).
- PTR_W, 2, width of the shadow pointer; must satisfy 2**PTR_W > SHADOW_DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_zero  input  1  ALU zero flag.
- alu_neg  input  1  ALU negative flag.
- alu_cout  input  1  ALU carry flag.
- alu_overflow  input  1  ALU overflow flag.
- ex_valid  input  1  execute stage holds a valid instruction.
- stall  input  1  pipeline stall; blocks all state updates except reset.
- upd_mask  input  4  per-flag write enable, bit order {V,C,N,Z}.
- br_cond  input  3  0 none, 1 JZ, 2 JN, 3 JC, 4 JV, 5 JMP, 6-7 none.
- int_save  input  1  push current flags to the shadow stack.
- rti_restore  input  1  pop flags from the shadow stack into the CCR.
- ccr  output  4  registered flags {V,C,N,Z}.
- carry_in  output  1  equals ccr[2]; consumed by the ALU for RLC/RRC.
- br_taken  output  1  combinational branch decision.
- shadow_empty  output  1  shadow pointer == 0.
- shadow_full  output  1  shadow pointer == SHADOW_DEPTH.
- ccr_err  output  1  sticky error flag.

Behaviour:
- Reset (async, high):
  - ccr=0, shadow pointer=0, shadow entries=0, ccr_err=0.
  - Resulting outputs: carry_in=0, br_taken=0, shadow_empty=1, shadow_full=0.
- Cycle enable: en = ~stall. When stall=1, no register changes (ccr, pointer, stack, err all hold).
- Flag write: when en & ex_valid, per bit i: ccr_upd[i] = upd_mask[i] ? alu_flag[i] : ccr[i].
  - Visible on ccr one cycle after the capture edge (latency 1).
- Branch decision:
  - br_taken = ex_valid & (JMP | (JZ&ccr[0]) | (JN&ccr[1]) | (JC&ccr[2]) | (JV&ccr[3])).
  - Codes 0, 6 and 7 give br_taken=0.
- Branch consume: a taken JZ/JN/JC/JV clears the tested flag at the next edge (when en).
  - If the same cycle's upd_mask writes that bit, the ALU value wins over the clear.
- Shadow push (int_save & en & ~rti_restore):
  - Writes ccr_next (flags after this cycle's update/clear) to entry[ptr]; ptr increments.
  - If full: push dropped, ptr holds, ccr_err set.
- Shadow pop (rti_restore & en & ~int_save):
  - ccr <= entry[ptr-1]; ptr decrements. The restore overrides any same-cycle flag write or branch clear.
  - If empty: ccr follows normal update, ptr holds, ccr_err set.
- int_save & rti_restore together: stack untouched, ccr follows normal update, ccr_err set.
- ccr_err is sticky; it clears only on reset.
- Priority for ccr_next: reset > valid pop > mask write > branch clear > hold.
- Reset mid-operation clears everything immediately, including a partially filled stack.
- Pointer never wraps; saturates at 0 and SHADOW_DEPTH.

Optional Feature:
- Macro CCR_FWD_EN.
- When defined: br_taken and carry_in use forwarded flags.
  - Forwarded flag = upd_mask[i] & ex_valid ? alu_flag[i] : ccr[i].
  - Gives a branch or rotate directly after a flag-writing instruction zero-bubble access.
- When undefined: both are driven from registered ccr only, and the hazard is left to the stall logic.

Decomposition:
- Shared package (cpu_pkg) holds:
  - flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3;
  - the br_cond encodings BR_NONE, BR_JZ, BR_JN, BR_JC, BR_JV, BR_JMP;
  - the ALU function codes shared with the ALU.
- One natural sub-module: ccr_shadow_stack (LIFO, pointer, full/empty, push/pop error detect).

Test Plan:
- Reset then ex_valid=1, upd_mask=4'b1111, flags V=0 C=1 N=1 Z=0 -> next cycle ccr=4'b0110, carry_in=1.
- ccr=4'b0001, br_cond=JZ, ex_valid=1, upd_mask=0 -> br_taken=1 same cycle, ccr=4'b0000 next cycle; repeat with upd_mask=4'b0001, alu_zero=1 -> ccr stays 4'b0001.
- ccr=4'b1010, int_save pulse -> ptr=1; write ccr=4'b0101; rti_restore pulse -> ccr=4'b1010, shadow_empty=1.
- Push three times with SHADOW_DEPTH=2 -> shadow_full=1 after second push, third dropped, ccr_err=1; pop on empty after reset -> ccr_err=1, ccr unchanged.
- stall=1 with ex_valid=1, upd_mask=4'b1111, int_save=1 -> ccr, pointer and err unchanged; assert reset mid-stack -> ccr=0, shadow_empty=1 asynchronously.
- With CCR_FWD_EN: ccr=0, ex_valid=1, upd_mask=4'b0100, alu_cout=1 -> carry_in=1 and JC br_taken=1 in the same cycle; without the macro both stay 0 until the next cycle.
